// File: rtl/cpu_step_ctrl.sv
// Debug step controller: gates the CPU clock enable for single/count/run-to-break
// runs and keeps a circular trace of {PC, instruction} for every executed step.
module cpu_step_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        MODE,
    input  logic              START,
    input  logic              STOP,
    input  logic [CNT_W-1:0]  STEP_N,
    input  logic              BRK_EN,
    input  logic [DATA_W-1:0] BRK_ADDR,
    input  logic [DATA_W-1:0] DBG_PC,
    input  logic [DATA_W-1:0] DBG_INST,
    input  logic [AW-1:0]     RD_IDX,
    output logic              CPU_EN,
    output logic              BUSY,
    output logic              DONE,
    output logic              HIT,
    output logic [CNT_W-1:0]  STEPS,
    output logic [DATA_W-1:0] TR_PC,
    output logic [DATA_W-1:0] TR_INST,
    output logic [AW:0]       TR_CNT,
    output logic              OVF
);

    localparam int unsigned EW   = 2 * DATA_W;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    localparam logic [1:0] M_NONE   = 2'b00;
    localparam logic [1:0] M_SINGLE = 2'b01;
    localparam logic [1:0] M_COUNT  = 2'b10;
    localparam logic [1:0] M_BRK    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [CNT_W-1:0]  steps_q;
    logic              hit_q;
    logic              ovf_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW:0]       tr_cnt_q;
    logic [DATA_W-1:0] tr_pc_q;
    logic [DATA_W-1:0] tr_inst_q;
    logic [EW-1:0]     trace_mem [DEPTH];

    logic              accept;
    logic              brk;
    logic              cpu_en_c;
    logic              set_hit;
    logic              counted;
    logic [AW-1:0]     rd_addr;
    logic              rd_valid;
    logic [EW-1:0]     rd_word;

    assign counted = (mode_q == M_SINGLE) || (mode_q == M_COUNT);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and run control strobes
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        brk      = 1'b0;
        cpu_en_c = 1'b0;
        set_hit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START && !STOP && (MODE != M_NONE)) begin
                    accept  = 1'b1;
                    state_d = ((MODE == M_COUNT) && (STEP_N == '0)) ? S_HALT : S_RUN;
                end
            end
            S_RUN: begin
                // steps_q != 0 lets a run that starts on the breakpoint advance
                brk      = (mode_q == M_BRK) && BRK_EN && (DBG_PC == BRK_ADDR)
                           && (steps_q != '0);
                cpu_en_c = !STOP && !brk;
                if (STOP) begin
                    state_d = S_HALT;
                end else if (brk) begin
                    state_d = S_HALT;
                    set_hit = 1'b1;
                end else if (counted && (remaining_q == CNT_W'(1))) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Run bookkeeping: latched mode, step counters, sticky flags, trace pointers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q      <= M_NONE;
            remaining_q <= '0;
            steps_q     <= '0;
            hit_q       <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            tr_cnt_q    <= '0;
        end else if (accept) begin
            mode_q      <= MODE;
            remaining_q <= (MODE == M_SINGLE) ? CNT_W'(1) : STEP_N;
            steps_q     <= '0;
            hit_q       <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            tr_cnt_q    <= '0;
        end else begin
            if (set_hit) begin
                hit_q <= 1'b1;
            end
            if (cpu_en_c) begin
                if (steps_q != '1) begin
                    steps_q <= steps_q + CNT_W'(1);
                end
                if (counted) begin
                    remaining_q <= remaining_q - CNT_W'(1);
                end
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (tr_cnt_q == FULL) begin
                    ovf_q <= 1'b1;
                end else begin
                    tr_cnt_q <= tr_cnt_q + (AW + 1)'(1);
                end
            end
        end
    end

    // Trace storage, deliberately unreset
    always_ff @(posedge CLK) begin
        if (cpu_en_c) begin
            trace_mem[wr_ptr_q] <= {DBG_PC, DBG_INST};
        end
    end

    // Once full, the oldest entry sits at the write pointer
    assign rd_addr  = (tr_cnt_q == FULL) ? (wr_ptr_q + RD_IDX) : RD_IDX;
    assign rd_valid = ({1'b0, RD_IDX} < tr_cnt_q);
    assign rd_word  = rd_valid ? trace_mem[rd_addr] : '0;

    // Registered trace read port
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tr_pc_q   <= '0;
            tr_inst_q <= '0;
        end else begin
            tr_pc_q   <= rd_word[EW-1:DATA_W];
            tr_inst_q <= rd_word[DATA_W-1:0];
        end
    end

    assign CPU_EN  = cpu_en_c;
    assign BUSY    = (state_q == S_RUN);
    assign DONE    = (state_q == S_HALT);
    assign HIT     = hit_q;
    assign STEPS   = steps_q;
    assign TR_PC   = tr_pc_q;
    assign TR_INST = tr_inst_q;
    assign TR_CNT  = tr_cnt_q;
    assign OVF     = ovf_q;

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the PC, instruction and breakpoint fields.
REQ-002 SHALL have parameter CNT_W, default 16, width of the step counters.
REQ-003 SHALL have parameter DEPTH, default 8, trace buffer entries, a power of 2 and at least 2; AW = log2(DEPTH).
REQ-004 SHALL use one clock, CLK; reset RST is asynchronous and active-high.
REQ-005 Ports SHALL be as follows (name  direction  width  meaning):
- CLK  in  1  clock
- RST  in  1  async active-high reset
- MODE  in  2  00 none, 01 single, 10 count, 11 run-to-break; latched at START
- START  in  1  begin a run (level sampled each cycle)
- STOP  in  1  abort a run
- STEP_N  in  CNT_W  step count for MODE=10; latched at START
- BRK_EN  in  1  breakpoint enable
- BRK_ADDR  in  DATA_W  breakpoint PC
- DBG_PC  in  DATA_W  current CPU PC
- DBG_INST  in  DATA_W  current CPU instruction
- RD_IDX  in  AW  trace read index; 0 = oldest entry
- CPU_EN  out  1  CPU clock enable; each high cycle is one step
- BUSY  out  1  state is RUN
- DONE  out  1  one-cycle pulse at end of a run
- HIT  out  1  sticky: run ended on a breakpoint
- STEPS  out  CNT_W  steps executed in the current or last run, saturating
- TR_PC  out  DATA_W  trace PC at RD_IDX
- TR_INST  out  DATA_W  trace instruction at RD_IDX
- TR_CNT  out  AW+1  valid trace entries, saturating at DEPTH
- OVF  out  1  sticky: trace overwrote its oldest entry

Function
REQ-006 FSM SHALL have exactly three states: IDLE, RUN, HALT.
REQ-007 IDLE: START=1, STOP=0 and MODE!=00 -> RUN next cycle, latching MODE and STEP_N (MODE=01 loads remaining=1) and clearing STEPS, HIT, OVF, TR_CNT and the write pointer.
REQ-008 IDLE: START with MODE=00, or START and STOP together, SHALL be ignored; state stays IDLE.
REQ-009 MODE=10 with STEP_N=0 SHALL go IDLE -> HALT directly, giving no CPU_EN cycle, STEPS=0 and a DONE pulse.
REQ-010 CPU_EN SHALL be combinational: RUN & ~STOP & ~brk, where brk = latched MODE=11 & BRK_EN & DBG_PC==BRK_ADDR & STEPS!=0.
REQ-011 The breakpoint SHALL be ignored on the first step of a run, so a run starting at BRK_ADDR advances.
REQ-012 On each CPU_EN cycle: STEPS increments, saturating at all-ones, and remaining decrements in modes 01/10.
REQ-013 RUN -> HALT SHALL occur when any of these holds:
- CPU_EN=1 and remaining=1 in mode 01/10;
- brk=1, which also sets HIT;
- STOP=1.
REQ-014 HALT SHALL last exactly one cycle with DONE=1, then go to IDLE.
REQ-015 START SHALL be ignored in RUN and HALT.
REQ-016 BUSY SHALL be 1 exactly in RUN; run latency is START cycle -> first CPU_EN in the next cycle.
REQ-017 Trace capture: on each CPU_EN cycle, write {DBG_PC, DBG_INST} at the write pointer.
REQ-018 Trace pointer and count:
- the write pointer increments modulo DEPTH;
- TR_CNT increments, saturating at DEPTH;
- a write when TR_CNT=DEPTH SHALL set OVF.
REQ-019 Trace read SHALL have 1-cycle latency.
REQ-020 Trace read addressing SHALL be:
- TR_CNT<DEPTH: entry RD_IDX;
- TR_CNT=DEPTH: entry (wr_ptr+RD_IDX) mod DEPTH;
- RD_IDX>=TR_CNT: output zero.
REQ-021 Trace contents SHALL survive the run's end and are readable in IDLE until the next accepted START.
REQ-022 Comparison and arithmetic SHALL be unsigned and exact width; no X-propagation from unwritten trace entries, which read as zero via REQ-020.

Reset
REQ-023 RST=1 SHALL asynchronously force:
- state IDLE;
- CPU_EN=0, BUSY=0, DONE=0, HIT=0, OVF=0;
- STEPS=0, TR_CNT=0, write pointer 0, TR_PC=0, TR_INST=0.
REQ-024 Trace RAM contents need no reset.
REQ-025 RST during RUN SHALL abort with no DONE pulse.
REQ-026 After RST deasserts, the first START SHALL be accepted on the first rising CLK edge.

Verification
REQ-027 Single step: MODE=01, START 1 cycle -> CPU_EN high exactly 1 cycle (next cycle), DONE 1 cycle later, STEPS=1, TR_CNT=1, trace[0] = PC/INST sampled in the CPU_EN cycle.
REQ-028 Count wrap: DEPTH=8, MODE=10, STEP_N=10, DBG_PC incrementing 0,4,8,... -> exactly 10 CPU_EN cycles, STEPS=10, TR_CNT=8, OVF=1, RD_IDX=0 gives PC=8 and RD_IDX=7 gives PC=36.
REQ-029 Breakpoint: MODE=11, BRK_EN=1, BRK_ADDR=0x10, PC starting at 0x10 stepping +4 and wrapping to 0x10 after 0x1C -> first step at 0x10 proceeds, halts before the second 0x10, STEPS=4, HIT=1.
REQ-030 Zero count and collision:
- MODE=10, STEP_N=0 -> no CPU_EN, DONE pulse, STEPS=0;
- START+STOP together in IDLE -> nothing happens.
REQ-031 Abort:
- STOP during step 3 of STEP_N=20 -> that cycle's CPU_EN is suppressed, STEPS=2, DONE pulses;
- RST mid-run -> all outputs reset immediately, no DONE.
